// File: rtl/serial_deglitch_multi.sv
// rtl/serial_deglitch_multi.sv - multi-channel deglitcher with programmable threshold and hysteresis
// Define SERIAL_DEGLITCH_EDGE_EN to get registered rise_o/fall_o edge pulses.
module serial_deglitch_multi #(
  parameter int                    CHANNELS = 8,
  parameter int                    CNT_W    = 4,
  parameter logic [CHANNELS-1:0]   INIT     = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic [CNT_W-1:0]    thr_i,
  input  logic [CHANNELS-1:0] d_i,
  output logic [CHANNELS-1:0] q_o,
  output logic [CHANNELS-1:0] rise_o,
  output logic [CHANNELS-1:0] fall_o
);

  logic [CNT_W-1:0]    thr_eff;
  logic [CHANNELS-1:0] q_nxt;

  // A zero threshold would never let the output move, so treat it as one sample.
  assign thr_eff = (thr_i == '0) ? CNT_W'(1) : thr_i;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] c;
    logic [CNT_W-1:0] cnt_n;
    logic             q;
    logic             q_n;

    always_comb begin
      // Clamp first so a lowered threshold takes effect on the very next sample.
      c = (cnt > thr_eff) ? thr_eff : cnt;
      if (d_i[i]) begin
        cnt_n = (c == thr_eff) ? thr_eff : c + 1'b1;
      end else begin
        cnt_n = (c == '0) ? '0 : c - 1'b1;
      end
      if (cnt_n == thr_eff) begin
        q_n = 1'b1;
      end else if (cnt_n == '0) begin
        q_n = 1'b0;
      end else begin
        q_n = q;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
        cnt <= INIT[i] ? thr_eff : '0;
        q   <= INIT[i];
      end else if (en_i) begin
        cnt <= cnt_n;
        q   <= q_n;
      end
    end

    assign q_o[i]   = q;
    assign q_nxt[i] = q_n;
  end

`ifdef SERIAL_DEGLITCH_EDGE_EN
  logic [CHANNELS-1:0] rise_r;
  logic [CHANNELS-1:0] fall_r;

  // Reset and clear may change q but must never look like a filtered edge.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i || !en_i) begin
      rise_r <= '0;
      fall_r <= '0;
    end else begin
      rise_r <= q_nxt & ~q_o;
      fall_r <= ~q_nxt & q_o;
    end
  end

  assign rise_o = rise_r;
  assign fall_o = fall_r;
`else
  logic unused_q_nxt;
  assign unused_q_nxt = ^q_nxt;
  assign rise_o = '0;
  assign fall_o = '0;
`endif

endmodule

// File: tb/tb_serial_deglitch_multi.sv
// tb/tb_serial_deglitch_multi.sv - randomized and directed bench for serial_deglitch_multi
module tb_serial_deglitch_multi;

  localparam int         CH      = 8;
  localparam int         W       = 4;
  localparam logic [7:0] INIT_V  = 8'h05;
`ifdef SERIAL_DEGLITCH_EDGE_EN
  localparam bit         EDGE_ON = 1'b1;
`else
  localparam bit         EDGE_ON = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          clr_i = 1'b0;
  logic          en_i  = 1'b0;
  logic [W-1:0]  thr_i = '0;
  logic [CH-1:0] d_i   = '0;
  logic [CH-1:0] q_o;
  logic [CH-1:0] rise_o;
  logic [CH-1:0] fall_o;

  int n_checks = 0;
  int n_fail   = 0;

  int         m_cnt [CH];
  logic [7:0] m_q, m_rise, m_fall;

  serial_deglitch_multi #(.CHANNELS(CH), .CNT_W(W), .INIT(INIT_V)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .en_i(en_i), .thr_i(thr_i),
    .d_i(d_i), .q_o(q_o), .rise_o(rise_o), .fall_o(fall_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: each channel is a saturating integer walk between 0 and T;
  // the output flips only when the walk touches an end.
  function automatic void model_step(input bit r, input bit c, input bit e,
                                     input int thr, input logic [7:0] d);
    int t = (thr == 0) ? 1 : thr;
    for (int i = 0; i < CH; i++) begin
      m_rise[i] = 1'b0;
      m_fall[i] = 1'b0;
      if (r || c) begin
        m_q[i]   = INIT_V[i];
        m_cnt[i] = INIT_V[i] ? t : 0;
      end else if (e) begin
        int v  = (m_cnt[i] < t) ? m_cnt[i] : t;
        bit nq;
        v  = d[i] ? ((v + 1 > t) ? t : v + 1) : ((v - 1 < 0) ? 0 : v - 1);
        nq = (v == t) ? 1'b1 : (v == 0) ? 1'b0 : m_q[i];
        m_rise[i] = EDGE_ON && nq && !m_q[i];
        m_fall[i] = EDGE_ON && !nq && m_q[i];
        m_q[i]    = nq;
        m_cnt[i]  = v;
      end
    end
  endfunction

  task automatic step(input bit r, input bit c, input bit e, input int thr, input logic [7:0] d);
    rst_i = r; clr_i = c; en_i = e; thr_i = W'(thr); d_i = d;
    model_step(r, c, e, thr, d);
    @(posedge clk_i);
    #1;
    check("q_o", 32'(q_o), 32'(m_q));
    check("rise_o", 32'(rise_o), 32'(m_rise));
    check("fall_o", 32'(fall_o), 32'(m_fall));
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] rd;
    int thr;
    bit r, c, e;

    step(1, 0, 0, 4, 8'h00);
    check("reset_q", 32'(q_o), 32'(INIT_V));

    // basic rise on ch3 and ch1 at T=4
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 1, 4, 8'h0A);
      check("basic_rise_q3", 32'(q_o[3]), (k == 4) ? 32'd1 : 32'd0);
      check("basic_rise_p3", 32'(rise_o[3]), (k == 4 && EDGE_ON) ? 32'd1 : 32'd0);
    end

    // glitch of 3 samples on ch6, then decay
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 1, 4, (k < 3) ? 8'h4A : 8'h0A);
      check("glitch_q6", 32'(q_o[6]), 32'd0);
    end

    // hysteresis on ch1: two zeros then ones, then four zeros
    step(0, 0, 1, 4, 8'h08);
    step(0, 0, 1, 4, 8'h08);
    step(0, 0, 1, 4, 8'h0A);
    step(0, 0, 1, 4, 8'h0A);
    check("hyst_q1", 32'(q_o[1]), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 1, 4, 8'h08);
      check("fall_q1", 32'(q_o[1]), (k == 4) ? 32'd0 : 32'd1);
      check("fall_p1", 32'(fall_o[1]), (k == 4 && EDGE_ON) ? 32'd1 : 32'd0);
    end

    // enable gating: ch5 reaches 2, freezes for 10 cycles, then needs only 2 more
    step(0, 0, 1, 4, 8'h28);
    step(0, 0, 1, 4, 8'h28);
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 0, 4, 8'($urandom));
      check("gate_q5", 32'(q_o[5]), 32'd0);
    end
    step(0, 0, 1, 4, 8'h28);
    check("gate_resume1", 32'(q_o[5]), 32'd0);
    step(0, 0, 1, 4, 8'h28);
    check("gate_resume2", 32'(q_o[5]), 32'd1);

    step(0, 1, 1, 4, 8'hFF);
    check("clear_q", 32'(q_o), 32'(INIT_V));
    check("clear_edges", 32'({rise_o, fall_o}), 32'd0);

    // thr=0 acts as T=1: output equals the sample just taken
    for (int k = 0; k < 30; k++) begin
      d = 8'($urandom);
      step(0, 0, 1, 0, d);
      check("thr0_track", 32'(q_o), 32'(d));
    end

    // lower threshold 15 -> 3 with counters at 10
    step(0, 1, 1, 15, 8'h00);
    for (int k = 0; k < 10; k++) step(0, 0, 1, 15, 8'hFF);
    check("thr15_q1_low", 32'(q_o[1]), 32'd0);
    step(0, 0, 1, 3, 8'hFF);
    check("thr_lower_q", 32'(q_o), 32'hFF);

    step(1, 1, 1, 7, 8'hFF);
    check("rst_prio_q", 32'(q_o), 32'(INIT_V));
    check("rst_prio_edges", 32'({rise_o, fall_o}), 32'd0);

    // randomized run with run-length biased inputs
    rd  = 8'($urandom);
    thr = 4;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < CH; i++)
        if ($urandom_range(5) == 0) rd[i] = ~rd[i];
      if ($urandom_range(49) == 0) thr = $urandom_range(15);
      e = ($urandom_range(9) != 0);
      c = ($urandom_range(199) == 0);
      r = ($urandom_range(499) == 0);
      step(r, c, e, thr, rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
